mod_instruction_fetch_unit: RTL



---
 rtl/mod_instruction_fetch_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mod_instruction_fetch_unit.sv
// mod_instruction_fetch_unit
//
// Sequential instruction fetch front-end. Drives the instruction ROM word
// address from its program counter, captures the returned instruction into
// an output register, and offers it to decode over a valid/ready handshake.
// Supports stalls, branch/jump redirects with flush, and stops fetching once
// the ROM reports the end of the program.
//
// Ports:
//   clk             - system clock, rising edge
//   rst_n           - asynchronous active-low reset
//   start           - level; leaves IDLE and begins fetching
//   address         - ROM word address (the PC register)
//   instruction     - ROM read data for address
//   mem_end         - ROM flag: address is past the last program word
//   redirect_valid  - branch/jump taken, single-cycle pulse
//   redirect_target - new word address for the PC
//   id_ready        - decode can accept the presented instruction
//   if_valid        - if_instruction/if_pc hold a valid instruction
//   if_instruction  - registered instruction
//   if_pc           - word address of if_instruction
//   halted          - end of program reached, fetch stopped
//   fetch_count     - saturating count of captured instructions

module mod_instruction_fetch_unit #(
  parameter logic [29:0] RESET_PC = 30'd0,
  parameter int          COUNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [29:0]        address,
  input  logic [31:0]        instruction,
  input  logic               mem_end,
  input  logic               redirect_valid,
  input  logic [29:0]        redirect_target,
  input  logic               id_ready,
  output logic               if_valid,
  output logic [31:0]        if_instruction,
  output logic [29:0]        if_pc,
  output logic               halted,
  output logic [COUNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_HALT
  } state_t;

  state_t               state_q, state_d;
  logic [29:0]          pc_q, pc_d;
  logic                 valid_q, valid_d;
  logic [31:0]          instr_q, instr_d;
  logic [29:0]          if_pc_q, if_pc_d;
  logic                 halted_q, halted_d;
  logic [COUNT_W-1:0]   count_q, count_d;

  logic                 slot_free;

  localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};
  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

  // The output register can take a new instruction when it is empty or its
  // current content is being accepted by decode this cycle.
  assign slot_free = ~valid_q | id_ready;

  // Next-state logic. Everything holds by default; a redirect always wins
  // over capture so the wrong-path instruction is never presented.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    if_pc_d  = if_pc_q;
    halted_d = halted_q;
    count_d  = count_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        if (redirect_valid) begin
          pc_d    = redirect_target;
          valid_d = 1'b0;
        end else if (slot_free && !mem_end) begin
          instr_d = instruction;
          if_pc_d = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + 30'd1;
          if (count_q != COUNT_MAX) begin
            count_d = count_q + COUNT_ONE;
          end
        end else if (slot_free) begin
          valid_d  = 1'b0;
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else if (mem_end) begin
          // Last instruction still waiting for decode; finish it first.
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (redirect_valid) begin
          pc_d    = redirect_target;
          valid_d = 1'b0;
          state_d = S_FETCH;
        end else if (id_ready) begin
          valid_d  = 1'b0;
          halted_d = 1'b1;
          state_d  = S_HALT;
        end
      end

      default: begin
        // S_HALT is terminal until reset.
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      instr_q  <= 32'd0;
      if_pc_q  <= 30'd0;
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      if_pc_q  <= if_pc_d;
      halted_q <= halted_d;
      count_q  <= count_d;
    end
  end

  assign address        = pc_q;
  assign if_valid       = valid_q;
  assign if_instruction = instr_q;
  assign if_pc          = if_pc_q;
  assign halted         = halted_q;
  assign fetch_count    = count_q;

endmodule
